seq_mag_compare: RTL and testbench

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands DIGIT bits per clock, starting at the most significant digit, and terminates early at the first differing digit. It supports unsigned and two's-complement modes, and uses a start/busy/done handshake. It replaces the fixed 4-bit combinational comparator in datapaths where wide operands would otherwise form a long single-cycle compare chain.

---
 rtl/seq_mag_compare_pkg.sv | 27 ++
 rtl/mag_cmp_digit.sv | 21 ++
 rtl/seq_mag_compare.sv | 147 ++++++++++++++
 tb/tb_seq_mag_compare.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mag_compare_pkg.sv
// Shared definitions for the digit-serial magnitude comparator.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package seq_mag_compare_pkg;

  // FSM encoding: IDLE waits for start, SCAN walks digits MSD first,
  // DONE is the single-cycle result strobe.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of DIGIT-bit slices in a WIDTH-bit operand.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Bits needed to hold a digit index 0..n-1; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mag_cmp_digit.sv
// Unsigned compare of one DIGIT-bit slice, one-hot gt/lt/eq result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module mag_cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // Exactly one of the three flags is high for any input pair.
  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/seq_mag_compare.sv
// Digit-serial magnitude comparator, MSD first, exits at first differing digit.
// Latency: k cycles from acceptance (1..NDIG), k = digits examined.
// Backpressure: start is only taken in IDLE or DONE; start during SCAN is dropped.
module seq_mag_compare
  import seq_mag_compare_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIGIT     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             e
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int IW   = idx_width(NDIG);
  localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

  // Reject parameter sets the digit slicing cannot represent.
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_mag_compare: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("seq_mag_compare: WIDTH (%0d) must be at least 2", WIDTH);
  end

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] a_adj;
  logic [WIDTH-1:0] b_adj;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             d_gt;
  logic             d_lt;
  logic             d_eq;

  // Offset-binary: flipping the sign bits makes a two's-complement compare
  // an unsigned one; only the top digit is affected. Then select digit idx.
  always_comb begin
    a_adj              = a_q;
    b_adj              = b_q;
    a_adj[WIDTH-1]     = a_q[WIDTH-1] ^ sgn_q;
    b_adj[WIDTH-1]     = b_q[WIDTH-1] ^ sgn_q;
    a_dig              = a_adj[int'(idx)*DIGIT +: DIGIT];
    b_dig              = b_adj[int'(idx)*DIGIT +: DIGIT];
  end

  mag_cmp_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a  (a_dig),
    .b  (b_dig),
    .gt (d_gt),
    .lt (d_lt),
    .eq (d_eq)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and acceptance: a new compare may start from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!d_eq || (idx == '0)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SCAN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, digit index down-counter and sticky result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      idx   <= IDX_TOP;
      g     <= 1'b0;
      l     <= 1'b0;
      e     <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= signed_mode & SIGNED_EN;
      idx   <= IDX_TOP;
      g     <= 1'b0;
      l     <= 1'b0;
      e     <= 1'b0;
    end else if (state == ST_SCAN) begin
      if (d_gt) begin
        g <= 1'b1;
      end else if (d_lt) begin
        l <= 1'b1;
      end else if (idx == '0) begin
        e <= 1'b1;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end

  // Status flags decode straight from the state register, so they are
  // mutually exclusive and free of any input-to-output path.
  always_comb begin
    busy = (state == ST_SCAN);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed bench for seq_mag_compare with WIDTH=16, DIGIT=4, signed path on.
// Latency: checks the exact done cycle and busy length of each compare.
// Backpressure: covers start ignored in SCAN and back-to-back start in DONE.
module tb_seq_mag_compare;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic        g;
  logic        l;
  logic        e;

  int checks = 0;
  int errors = 0;

  seq_mag_compare #(
    .WIDTH     (16),
    .DIGIT     (4),
    .SIGNED_EN (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .g           (g),
    .l           (l),
    .e           (e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; return at the falling edge after T0.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sm);
    start       = 1'b1;
    a           = av;
    b           = bv;
    signed_mode = sm;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the falling edge after T0 (or later), wait for done with a bound,
  // then check latency, busy length and the one-hot result.
  task automatic wait_done(input string tag, input int k,
                           input logic eg, input logic el, input logic ee);
    int cyc;
    int bcnt;
    bit seen;
    cyc  = 0;
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_latency"}, cyc, k);
    chk({tag, "_busy_cycles"}, bcnt, k);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_g"}, int'(g), int'(eg));
    chk({tag, "_l"}, int'(l), int'(el));
    chk({tag, "_e"}, int'(e), int'(ee));
  endtask

  initial begin
    int dcnt;
    rst         = 1'b1;
    start       = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_g", int'(g), 0);
    chk("rst_l", int'(l), 0);
    chk("rst_e", int'(e), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Equal operands: all four digits examined.
    issue(16'h1234, 16'h1234, 1'b0);
    wait_done("eq_1234", 4, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_pulse_width", int'(done), 0);

    // Top-digit difference, unsigned then signed.
    issue(16'h8000, 16'h7FFF, 1'b0);
    wait_done("top_uns", 1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    issue(16'h8000, 16'h7FFF, 1'b1);
    wait_done("top_sgn", 1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    issue(16'h7FFF, 16'h8000, 1'b1);
    wait_done("top_sgn_rev", 1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Third digit from the top differs.
    issue(16'h12F4, 16'h1204, 1'b0);
    wait_done("mid", 3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Negative signed operands differing only in the last digit.
    issue(16'hFFFF, 16'hFFFE, 1'b1);
    wait_done("neg_gt", 4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    issue(16'h8000, 16'h8001, 1'b1);
    wait_done("neg_lt", 4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // start during SCAN with operands that would give l at once: ignored.
    issue(16'h12F4, 16'h1204, 1'b0);
    start = 1'b1;
    a     = 16'h0000;
    b     = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_scan", 2, 1'b1, 1'b0, 1'b0);

    // start in the done cycle: accepted, outputs cleared on that edge.
    issue(16'h0001, 16'h0002, 1'b0);
    chk("b2b_done_after", int'(done), 0);
    chk("b2b_busy_after", int'(busy), 1);
    chk("b2b_g_clr", int'(g), 0);
    chk("b2b_l_clr", int'(l), 0);
    chk("b2b_e_clr", int'(e), 0);
    wait_done("b2b", 4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset two edges into a four-digit compare.
    issue(16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_g", int'(g), 0);
    chk("mid_rst_l", int'(l), 0);
    chk("mid_rst_e", int'(e), 0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);

    // Normal operation after the reset.
    issue(16'h00A0, 16'h00B0, 1'b0);
    wait_done("post_rst", 3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_idle", int'(busy | done), 0);
    chk("post_rst_hold_l", int'(l), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
